// File: rtl/dp_mem_responder_pkg.sv
// Shared types for the memory-side responder: RAM handshake state, word type, responder FSM.
// Pure declarations, no logic.
package dp_mem_responder_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [1:0] {IDLE, DACC, IACC, HALTED} resp_state_t;

endpackage

// File: rtl/ibuf_entry.sv
// One-entry instruction buffer: fill on RAM fetch, drop on matching store, zero-latency compare.
// Latency: hit is combinational on lookup_addr; fill/invalidate take effect next cycle.
module ibuf_entry
  import dp_mem_responder_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  fill,
  input  word_t fill_addr,
  input  word_t fill_data,
  input  logic  inval,
  input  word_t inval_addr,
  input  word_t lookup_addr,
  output logic  hit,
  output word_t data
);

  logic  valid;
  word_t addr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      addr  <= fill_addr;
      data  <= fill_data;
    end else if (inval && inval_addr == addr) begin
      valid <= 1'b0;
    end
  end

  assign hit = valid && (lookup_addr == addr);

endmodule

// File: rtl/dp_mem_responder.sv
// Serves imem/dmem requests over one RAM port (dmem first); hits pulse in the RAM ACCESS cycle, ibuf hits in the request cycle.
// Backpressure: requester holds REN/WEN until its hit; RAM stalls via ramstate, bounded by TIMEOUT.
module dp_mem_responder
  import dp_mem_responder_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter bit IBUF_EN = 1'b1
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      halt,
  input  logic      imemREN,
  input  word_t     imemaddr,
  input  logic      dmemREN,
  input  logic      dmemWEN,
  input  word_t     dmemaddr,
  input  word_t     dmemstore,
  output logic      ihit,
  output word_t     imemload,
  output logic      dhit,
  output word_t     dmemload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      memerr
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  resp_state_t   state;
  word_t         lat_addr, lat_store;
  logic          lat_wen, halt_seen;
  logic [CW-1:0] wait_cnt;

  logic  in_acc, acc_ok, acc_err, done;
  logic  ibuf_match, ibuf_hit_now, ibuf_fill, ibuf_inval;
  word_t ibuf_data;

  assign in_acc  = (state == DACC) || (state == IACC);
  assign acc_ok  = in_acc && (ramstate == ACCESS);
  assign acc_err = in_acc && !acc_ok && ((ramstate == ERROR) || (wait_cnt == CW'(TIMEOUT - 1)));
  assign done    = acc_ok || acc_err;

  // Buffer hit only when nothing of higher priority claims this IDLE cycle.
  assign ibuf_hit_now = IBUF_EN && (state == IDLE) && !halt && !dmemREN && !dmemWEN
                        && imemREN && ibuf_match;

  assign ihit     = ibuf_hit_now || ((state == IACC) && done);
  assign imemload = ibuf_hit_now ? ibuf_data :
                    ((state == IACC) && acc_ok) ? ramload : '0;
  assign dhit     = (state == DACC) && done;
  assign dmemload = ((state == DACC) && acc_ok && !lat_wen) ? ramload : '0;

  assign ramREN   = (state == IACC) || ((state == DACC) && !lat_wen);
  assign ramWEN   = (state == DACC) && lat_wen;
  assign ramaddr  = in_acc ? lat_addr : '0;
  assign ramstore = ramWEN ? lat_store : '0;

  assign ibuf_fill  = IBUF_EN && (state == IACC) && acc_ok;
  assign ibuf_inval = (state == DACC) && done && lat_wen;

  ibuf_entry u_ibuf (
    .CLK         (CLK),
    .nRST        (nRST),
    .fill        (ibuf_fill),
    .fill_addr   (lat_addr),
    .fill_data   (ramload),
    .inval       (ibuf_inval),
    .inval_addr  (lat_addr),
    .lookup_addr (imemaddr),
    .hit         (ibuf_match),
    .data        (ibuf_data)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_store <= '0;
      lat_wen   <= 1'b0;
      halt_seen <= 1'b0;
      wait_cnt  <= '0;
      memerr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt  <= '0;
          halt_seen <= 1'b0;
          if (halt) begin
            state <= HALTED;
          end else if (dmemREN || dmemWEN) begin
            state     <= DACC;
            lat_addr  <= dmemaddr;
            lat_store <= dmemstore;
            lat_wen   <= dmemWEN;
          end else if (imemREN && !ibuf_hit_now) begin
            state    <= IACC;
            lat_addr <= imemaddr;
            lat_wen  <= 1'b0;
          end
        end
        DACC, IACC: begin
          if (halt) halt_seen <= 1'b1;
          // A halt raised mid-access lets the access finish before parking.
          if (done) begin
            wait_cnt <= '0;
            state    <= (halt || halt_seen) ? HALTED : IDLE;
            if (acc_err) memerr <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_mem_responder.sv
// Bench for dp_mem_responder: directed requests against a behavioural RAM with programmable latency,
// expected load data queued at issue time and compared by an independent hit monitor.
module tb_dp_mem_responder;
  import dp_mem_responder_pkg::*;

  logic      CLK = 1'b0, nRST = 1'b0, halt = 1'b0;
  logic      imemREN = 1'b0, dmemREN = 1'b0, dmemWEN = 1'b0;
  word_t     imemaddr = '0, dmemaddr = '0, dmemstore = '0;
  logic      ihit, dhit, ramREN, ramWEN, memerr;
  word_t     imemload, dmemload, ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  int vectors = 0, miscompares = 0;
  word_t exp_i[$], exp_d[$];

  logic [31:0] mem [256];
  logic [32:0] acc_log[$];
  int ram_lat = 2, rcnt = 0, ren_cycles = 0;
  bit ram_busy = 1'b0, ram_error = 1'b0;
  int i_cyc, d_cyc, ren_delta;

  dp_mem_responder #(.TIMEOUT(8), .IBUF_EN(1'b1)) dut (
    .CLK(CLK), .nRST(nRST), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .ihit(ihit), .imemload(imemload), .dhit(dhit), .dmemload(dmemload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  always #5 CLK = ~CLK;

  // RAM: ACCESS on the ram_lat-th consecutive strobe cycle unless forced BUSY/ERROR.
  always_comb begin
    ramstate = FREE;
    ramload  = '0;
    if (ramREN || ramWEN) begin
      if (ram_error) ramstate = ERROR;
      else if (ram_busy || rcnt < ram_lat - 1) ramstate = BUSY;
      else ramstate = ACCESS;
      if (ramstate == ACCESS && ramREN) ramload = mem[ramaddr[9:2]];
    end
  end

  always @(posedge CLK) begin
    if (!nRST) begin
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h40] <= 32'h8C220004;
      mem[8'h41] <= 32'hCAFEF00D;
    end else if (ramstate == ACCESS && ramWEN) begin
      mem[ramaddr[9:2]] <= ramstore;
    end
    if (ramstate == ACCESS) acc_log.push_back({ramWEN, ramaddr});
    rcnt <= (!(ramREN || ramWEN) || ramstate == ACCESS) ? 0 : rcnt + 1;
    if (ramREN) ren_cycles <= ren_cycles + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (nRST) begin
      if (dhit) begin
        if (exp_d.size() == 0) chk("dhit_unexpected", 32'(dhit), 32'd0);
        else chk("dmemload", dmemload, exp_d.pop_front());
      end
      if (ihit) begin
        if (exp_i.size() == 0) chk("ihit_unexpected", 32'(ihit), 32'd0);
        else chk("imemload", imemload, exp_i.pop_front());
      end
    end
  end

  // Issue requests, hold each until its hit, report hit cycle (request cycle = 1).
  task automatic serve(input bit i_req, input word_t ia, input bit d_ren, input bit d_wen,
                       input word_t da, input word_t ds, input word_t ei, input word_t ed);
    bit i_pend, d_pend;
    int ren0;
    i_pend = i_req;
    d_pend = d_ren | d_wen;
    if (i_pend) exp_i.push_back(ei);
    if (d_pend) exp_d.push_back(ed);
    i_cyc = 0;
    d_cyc = 0;
    @(posedge CLK); #1;
    imemREN = i_req; imemaddr = ia;
    dmemREN = d_ren; dmemWEN = d_wen; dmemaddr = da; dmemstore = ds;
    ren0 = ren_cycles;
    for (int c = 1; c <= 20 && (i_pend || d_pend); c++) begin
      @(negedge CLK);
      if (dhit && d_pend) begin d_pend = 1'b0; d_cyc = c; end
      if (ihit && i_pend) begin i_pend = 1'b0; i_cyc = c; end
      @(posedge CLK); #1;
      if (d_pend) begin
        dmemaddr  = $urandom & 32'h3FC;
        dmemstore = $urandom;
      end else begin
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
      end
      if (!i_pend) imemREN = 1'b0;
    end
    if (i_pend || d_pend) chk("serve_timeout", {30'd0, i_pend, d_pend}, 32'd0);
    imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    ren_delta = ren_cycles - ren0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int n0;
    bit got;
    #1;
    chk("rst_outputs", {26'd0, ihit, dhit, ramREN, ramWEN, memerr, 1'b0}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    // Data read, ACCESS on the 3rd RAM cycle.
    ram_lat = 3;
    serve(0, '0, 1, 0, 32'h40, '0, '0, 32'hDEADBEEF);
    chk("t1_dhit_cycle", d_cyc, 4);
    chk("t1_ren_cycles", ren_delta, 3);
    @(negedge CLK);
    chk("t1_dhit_pulse", 32'(dhit), 32'd0);

    // Fetch then refetch: second must hit the buffer with no RAM traffic.
    ram_lat = 2;
    serve(1, 32'h100, 0, 0, '0, '0, 32'h8C220004, '0);
    chk("t2_fetch_cycle", i_cyc, 3);
    serve(1, 32'h100, 0, 0, '0, '0, 32'h8C220004, '0);
    chk("t2_ibuf_cycle", i_cyc, 1);
    chk("t2_ibuf_noram", ren_delta, 0);

    // Simultaneous fetch and store: store first.
    n0 = acc_log.size();
    serve(1, 32'h104, 0, 1, 32'h200, 32'h12345678, 32'hCAFEF00D, 32'h0);
    chk("t3_dhit_cycle", d_cyc, 3);
    chk("t3_ihit_cycle", i_cyc, 6);
    chk("t3_first_addr", acc_log[n0][31:0], 32'h200);
    chk("t3_first_wen", 32'(acc_log[n0][32]), 32'd1);
    chk("t3_second_addr", acc_log[n0+1][31:0], 32'h104);
    chk("t3_second_wen", 32'(acc_log[n0+1][32]), 32'd0);

    // Store to the buffered address must force the next fetch to RAM.
    serve(1, 32'h100, 0, 0, '0, '0, 32'h8C220004, '0);
    chk("t4_miss_cycle", i_cyc, 3);
    serve(1, 32'h100, 0, 0, '0, '0, 32'h8C220004, '0);
    chk("t4_hit_cycle", i_cyc, 1);
    serve(0, '0, 0, 1, 32'h100, 32'hFFFFFFFF, '0, 32'h0);
    chk("t4_store_cycle", d_cyc, 3);
    serve(1, 32'h100, 0, 0, '0, '0, 32'hFFFFFFFF, '0);
    chk("t4_refetch_cycle", i_cyc, 3);
    chk("t4_refetch_ram", ren_delta, 2);

    serve(0, '0, 1, 0, 32'h200, '0, '0, 32'h12345678);
    chk("t5_read_cycle", d_cyc, 3);
    chk("t5_memerr_clear", 32'(memerr), 32'd0);

    // RAM stuck BUSY: forced completion on the 8th wait cycle.
    ram_busy = 1'b1;
    serve(0, '0, 1, 0, 32'h40, '0, '0, 32'h0);
    ram_busy = 1'b0;
    chk("t6_timeout_cycle", d_cyc, 9);
    chk("t6_ren_cycles", ren_delta, 8);
    chk("t6_memerr_set", 32'(memerr), 32'd1);
    repeat (3) @(negedge CLK);
    chk("t6_memerr_sticky", 32'(memerr), 32'd1);

    // RAM ERROR: zero data, buffer not filled.
    ram_error = 1'b1;
    serve(1, 32'h40, 0, 0, '0, '0, 32'h0, '0);
    ram_error = 1'b0;
    chk("t7_err_cycle", i_cyc, 2);
    serve(1, 32'h40, 0, 0, '0, '0, 32'hDEADBEEF, '0);
    chk("t7_nofill_cycle", i_cyc, 3);

    // Halt during a fetch.
    ram_lat = 3;
    exp_i.push_back(32'hCAFEF00D);
    @(posedge CLK); #1;
    imemREN = 1'b1; imemaddr = 32'h104;
    @(posedge CLK); #1;
    halt = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge CLK);
      if (ihit) got = 1'b1;
    end
    chk("t8_halt_ihit", 32'(got), 32'd1);
    @(posedge CLK); #1;
    dmemREN = 1'b1; dmemaddr = 32'h40;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      chk("t8_halted_quiet", {28'd0, ihit, dhit, ramREN, ramWEN}, 32'd0);
    end

    // Reset in the middle of a data access.
    halt = 1'b0; imemREN = 1'b0; dmemREN = 1'b0;
    nRST = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    ram_busy = 1'b1;
    dmemREN = 1'b1; dmemaddr = 32'h40;
    @(posedge CLK); #1;
    chk("t9_ren_active", 32'(ramREN), 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("t9_ren_drop", 32'(ramREN), 32'd0);
    chk("t9_addr_drop", ramaddr, 32'd0);
    dmemREN = 1'b0; ram_busy = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    chk("t9_memerr_rst", 32'(memerr), 32'd0);
    ram_lat = 2;
    serve(1, 32'h104, 0, 0, '0, '0, 32'hCAFEF00D, '0);
    chk("t9_ibuf_invalid", i_cyc, 3);

    repeat (2) @(negedge CLK);
    chk("queues_drained", exp_i.size() + exp_d.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
